// File: rtl/decrypt_function_3_pkg.sv
// rtl/decrypt_function_3_pkg.sv - shared widths, field offsets and key-mask builder for the function-3 crypt pair
package decrypt_function_3_pkg;

   localparam int DATA_W  = 60;
   localparam int KEY_W   = 11;
   localparam int TAG_W   = 6;
   localparam int X_W     = 61;
   localparam int ENC_W   = 78;
   localparam int X_LSB   = 17;
   localparam int KEY_LSB = 6;

   typedef struct packed {
      logic [X_W-1:0]    x;
      logic [DATA_W-1:0] b;
      logic [KEY_W-1:0]  key;
      logic [TAG_W-1:0]  tag;
   } s1_t;

   // Segments from LSB: ~r, r, r, ~r, r, then the low 5 bits of r on top.
   function automatic logic [DATA_W-1:0] make_key_f3(input logic [KEY_W-1:0] r);
      return {r[4:0], r, ~r, r, r, ~r};
   endfunction

endpackage

// File: rtl/decrypt_function_3_key_mask.sv
// rtl/decrypt_function_3_key_mask.sv - combinational function-3 key mask builder, shared with the encryptor
module key_mask_f3
   import decrypt_function_3_pkg::*;
(
   input  logic [KEY_W-1:0]  rand_11,
   output logic [DATA_W-1:0] mask
);

   assign mask = make_key_f3(rand_11);

endmodule

// File: rtl/decrypt_function_3.sv
// rtl/decrypt_function_3.sv - two-stage valid/ready function-3 frame decryptor with saturating counters
module decrypt_function_3
   import decrypt_function_3_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ENC_W-1:0]  inEnc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] dec_data,
   output logic [TAG_W-1:0]  tag_out,
   output logic [KEY_W-1:0]  key_out,
   output logic              err,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   logic              adv;
   logic [DATA_W-1:0] mask;
   logic [X_W:0]      diff;

   s1_t               s1_q, s1_d;
   logic              v1_q, v1_d;
   logic              v2_q, v2_d;
   logic [DATA_W-1:0] dec_q, dec_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [KEY_W-1:0]  key_q, key_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   key_mask_f3 u_key_mask (
      .rand_11 (inEnc[X_LSB-1:KEY_LSB]),
      .mask    (mask)
   );

   assign adv      = ~v2_q | out_ready;
   assign in_ready = adv & Rst_n;

   always_comb begin
      s1_d        = s1_q;
      v1_d        = v1_q;
      v2_d        = v2_q;
      dec_d       = dec_q;
      tag_d       = tag_q;
      key_d       = key_q;
      err_d       = err_q;
      frame_cnt_d = frame_cnt_q;
      err_cnt_d   = err_cnt_q;

      // Bit 61 flags x < b, bit 60 flags a result too wide for the plaintext.
      diff = {1'b0, s1_q.x} - {2'b00, s1_q.b};

      if (adv) begin
         s1_d.x   = inEnc[ENC_W-1:X_LSB];
         s1_d.b   = mask;
         s1_d.key = inEnc[X_LSB-1:KEY_LSB];
         s1_d.tag = inEnc[KEY_LSB-1:0];
         v1_d     = in_valid & in_ready;

         dec_d = diff[DATA_W-1:0];
         err_d = diff[X_W] | diff[X_W-1];
         tag_d = s1_q.tag;
         key_d = s1_q.key;
         v2_d  = v1_q;
      end

      if (v2_q & out_ready) begin
         if (~&frame_cnt_q) frame_cnt_d = frame_cnt_q + CNT_ONE;
         if (err_q & ~&err_cnt_q) err_cnt_d = err_cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         s1_q        <= '0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         dec_q       <= '0;
         tag_q       <= '0;
         key_q       <= '0;
         err_q       <= 1'b0;
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         s1_q        <= s1_d;
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         dec_q       <= dec_d;
         tag_q       <= tag_d;
         key_q       <= key_d;
         err_q       <= err_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign out_valid = v2_q;
   assign dec_data  = dec_q;
   assign tag_out   = tag_q;
   assign key_out   = key_q;
   assign err       = err_q;
   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_decrypt_function_3.sv
// tb/tb_decrypt_function_3.sv - directed and round-trip bench for decrypt_function_3
module tb_decrypt_function_3;

   logic        Clk = 1'b0;
   logic        Rst_n;
   logic        in_valid;
   logic [77:0] inEnc;
   logic        out_ready;

   logic        in_ready, out_valid, err;
   logic [59:0] dec_data;
   logic [5:0]  tag_out;
   logic [10:0] key_out;
   logic [15:0] frame_cnt, err_cnt;

   logic        in_ready4, out_valid4, err4;
   logic [59:0] dec_data4;
   logic [5:0]  tag_out4;
   logic [10:0] key_out4;
   logic [3:0]  frame_cnt4, err_cnt4;

   int checks = 0;
   int failures = 0;
   int delivered = 0;
   int err_delivered = 0;
   bit mon_en = 1'b0;

   typedef struct packed {
      logic [77:0] enc;
      logic [59:0] dec;
      logic        err;
   } vec_t;

   vec_t in_q[$];
   vec_t exp_q[$];

   always #5 Clk = ~Clk;

   decrypt_function_3 #(.CNT_W(16)) u_dut (
      .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready), .inEnc(inEnc),
      .out_valid(out_valid), .out_ready(out_ready), .dec_data(dec_data), .tag_out(tag_out),
      .key_out(key_out), .err(err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   decrypt_function_3 #(.CNT_W(4)) u_dut4 (
      .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready4), .inEnc(inEnc),
      .out_valid(out_valid4), .out_ready(out_ready), .dec_data(dec_data4), .tag_out(tag_out4),
      .key_out(key_out4), .err(err4), .frame_cnt(frame_cnt4), .err_cnt(err_cnt4)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Bit-by-bit reference: segment i/11 picks rand_11[i%11], segments 0 and 3 inverted.
   function automatic logic [59:0] mask_ref(input logic [10:0] k);
      logic [59:0] m;
      for (int i = 0; i < 60; i++) begin
         m[i] = k[i % 11] ^ ((i / 11 == 0) || (i / 11 == 3));
      end
      return m;
   endfunction

   function automatic vec_t rt_vec(input logic [59:0] p, input logic [10:0] k, input logic [5:0] t);
      vec_t v;
      logic [60:0] x;
      x = {1'b0, p} + {1'b0, mask_ref(k)};
      v.enc = {x, k, t};
      v.dec = p;
      v.err = 1'b0;
      return v;
   endfunction

   function automatic vec_t rand_vec();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return rt_vec(r[59:0], 11'($urandom()), 6'($urandom()));
   endfunction

   function automatic logic [63:0] sat(input int n, input int maxv);
      return (n > maxv) ? 64'(maxv) : 64'(n);
   endfunction

   always @(negedge Clk) begin
      if (mon_en && Rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", {63'b0, out_valid}, 64'd0);
         end else begin
            check("dec_data", {4'b0, dec_data}, {4'b0, exp_q[0].dec});
            check("tag_out", {58'b0, tag_out}, {58'b0, exp_q[0].enc[5:0]});
            check("key_out", {53'b0, key_out}, {53'b0, exp_q[0].enc[16:6]});
            check("err", {63'b0, err}, {63'b0, exp_q[0].err});
            if (!out_ready) begin
               check("in_ready_stall", {63'b0, in_ready}, 64'd0);
            end else begin
               if (exp_q[0].err) err_delivered++;
               delivered++;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // mode 0: out_ready high, 1: out_ready low for cycles 3..6, 2: random out_ready
   task automatic run(input int mode, input int budget);
      int cyc = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         @(posedge Clk); #1;
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !(cyc >= 3 && cyc <= 6) : 1'($urandom_range(0, 1));
         in_valid = in_q.size() > 0;
         if (in_valid) inEnc = in_q[0].enc;
         @(negedge Clk);
         if (in_valid && in_ready) exp_q.push_back(in_q.pop_front());
         cyc++;
      end
      check("run_drained", 64'(in_q.size() + exp_q.size()), 64'd0);
      @(posedge Clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic check_counts();
      check("frame_cnt", {48'b0, frame_cnt}, sat(delivered, 65535));
      check("err_cnt", {48'b0, err_cnt}, sat(err_delivered, 65535));
      check("frame_cnt4", {60'b0, frame_cnt4}, sat(delivered, 15));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      Rst_n = 1'b0;
      in_valid = 1'b0;
      inEnc = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      check("rst_in_ready", {63'b0, in_ready}, 64'd0);
      check("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_dec_data", {4'b0, dec_data}, 64'd0);
      check("rst_frame_cnt", {48'b0, frame_cnt}, 64'd0);
      Rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
      mon_en = 1'b1;

      v.enc = {61'h0000FFE000007FF, 11'h000, 6'h2A}; v.dec = 60'h0; v.err = 1'b0;
      in_q.push_back(v); run(0, 50); check_counts();
      v.enc = {61'h0FFFF001FFFFF801, 11'h7FF, 6'h01}; v.dec = 60'h000000000000001; v.err = 1'b0;
      in_q.push_back(v); run(0, 50); check_counts();
      v.enc = {61'h0, 11'h000, 6'h15}; v.dec = 60'hFFFF001FFFFF801; v.err = 1'b1;
      in_q.push_back(v); run(0, 50); check_counts();
      v.enc = {61'h1FFFFFFFFFFFFFFF, 11'h000, 6'h3F}; v.dec = 60'hFFFF001FFFFF800; v.err = 1'b1;
      in_q.push_back(v); run(0, 50); check_counts();

      for (int i = 0; i < 8; i++) in_q.push_back(rand_vec());
      run(1, 100);
      check_counts();

      for (int i = 0; i < 300; i++) in_q.push_back(rand_vec());
      run(2, 4000);
      check_counts();

      // Two frames in flight under stall, then reset.
      mon_en = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b1;
      inEnc = rand_vec().enc;
      repeat (2) @(posedge Clk);
      #1;
      check("pre_rst_out_valid", {63'b0, out_valid}, 64'd1);
      in_valid = 1'b0;
      Rst_n = 1'b0;
      @(posedge Clk); #1;
      check("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
      check("mid_rst_frame_cnt", {48'b0, frame_cnt}, 64'd0);
      check("mid_rst_err_cnt", {48'b0, err_cnt}, 64'd0);
      Rst_n = 1'b1;
      out_ready = 1'b1;
      in_q.delete();
      exp_q.delete();
      delivered = 0;
      err_delivered = 0;
      mon_en = 1'b1;
      repeat (5) @(posedge Clk);
      #1;
      check("post_rst_no_stale", {63'b0, out_valid}, 64'd0);
      check("post_rst_frame_cnt", {48'b0, frame_cnt}, 64'd0);

      for (int i = 0; i < 20; i++) in_q.push_back(rand_vec());
      run(0, 100);
      check("sat_frame_cnt4", {60'b0, frame_cnt4}, 64'd15);
      check("sat_frame_cnt16", {48'b0, frame_cnt}, 64'd20);
      check_counts();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decrypt_function_3.md
Name: decrypt_function_3

Overview:
- Receive-side counterpart of the function-3 encryptor. Accepts one 78-bit encrypted frame {x[60:0], rand_11[10:0], rand_6[5:0]}.
- Rebuilds the 60-bit key mask from the embedded rand_11, subtracts it from x, and recovers the 60-bit plaintext.
- Flags frames whose x cannot have come from a valid 60-bit plaintext.
- 2-stage valid/ready pipeline between the link/deserializer and the plaintext consumer, with saturating frame/error counters.

Parameters:
- CNT_W, 16, width of the frame and error counters.
- Data, key and tag widths are fixed at 60/11/6 (encoded word 78) by the key pattern and are package constants, not parameters.

Ports:
- Clk  in  1  clock; all logic on rising edge.
- Rst_n  in  1  synchronous active-low reset, sampled on posedge Clk.
- in_valid  in  1  inEnc holds a frame.
- in_ready  out  1  block can accept a frame this cycle.
- inEnc  in  78  [77:17]=x, [16:6]=rand_11, [5:0]=rand_6.
- out_valid  out  1  dec_data/tag_out/err valid.
- out_ready  in  1  consumer accepts output this cycle.
- dec_data  out  60  recovered plaintext, x-b truncated to 60 bits.
- tag_out  out  6  rand_6 passed through.
- key_out  out  11  rand_11 passed through.
- err  out  1  frame integrity error.
- frame_cnt  out  CNT_W  frames delivered; saturating.
- err_cnt  out  CNT_W  delivered frames with err=1; saturating.

Behaviour:
- Reset (Rst_n=0 at posedge): both stage valids, out_valid, dec_data, tag_out, key_out, err, frame_cnt and err_cnt all go to 0. in_ready is 0 during reset and 1 on the first cycle after.
- Reset mid-operation discards in-flight frames without delivering them; the counters clear.
- Handshakes:
  - Input transfer on in_valid & in_ready. Output transfer on out_valid & out_ready.
  - out_valid, once high, holds until transfer; dec_data, tag_out, key_out and err stay stable meanwhile.
- Pipeline enable: adv = ~out_valid | out_ready. in_ready = adv (combinational from out_ready; a registered skid variant is not required).
- Stage 1 (on adv):
  - Latches x, rand_11 and rand_6 from inEnc.
  - Builds key mask b[59:0]:
    - [10:0] = ~rand_11
    - [21:11] = rand_11
    - [32:22] = rand_11
    - [43:33] = ~rand_11
    - [54:44] = rand_11
    - [59:55] = rand_11[4:0]
  - Stage-1 valid takes in_valid & in_ready.
- Stage 2 (on adv):
  - Computes diff = {1'b0,x} - {2'b0,b} in 62 bits.
  - dec_data = diff[59:0].
  - err = diff[61] (x<b, underflow) | diff[60] (diff ≥ 2^60).
  - Stage-2 valid = out_valid takes the stage-1 valid.
- Latency: 2 cycles from input transfer to out_valid when unstalled; throughput 1 frame/cycle.
- Stall: when out_valid & ~out_ready, both stages hold and in_ready=0. No frame is dropped or duplicated.
- Counters: on each output transfer frame_cnt += 1, and err_cnt += 1 if err. Both saturate at all-ones with no wrap.
- Same-cycle input and output transfers are legal and both take effect.
- No bubbles are inserted when full and out_ready is held high.

Decomposition:
- Shared package (e.g. crypt_pkg):
  - DATA_W=60, KEY_W=11, TAG_W=6, X_W=61, ENC_W=78.
  - Field offsets: X_LSB=17, KEY_LSB=6.
  - Function make_key_f3(rand_11) returning b; the encryptor also uses it.
- One natural sub-module: key_mask_f3, the combinational mask builder wrapping the package function, shared with encrypt_function_3.

Test Plan:
- Known vector, data 0: x=0x0000FFE000007FF, rand_11=0x000, rand_6=0x2A → after 2 cycles dec_data=0, tag_out=0x2A, key_out=0, err=0, frame_cnt=1.
- Known vector, data 1: x=0xFFFF001FFFFF801, rand_11=0x7FF, rand_6=0x01 → dec_data=0x000000000000001, err=0.
- Underflow: x=0, rand_11=0 → err=1, dec_data=(0 − 0x0000FFE000007FF) mod 2^60 = 0xFFFF001FFFFF801, err_cnt=1.
- Overflow: x=0x1FFFFFFFFFFFFFFF, rand_11=0 → err=1. Random round-trip of 10^4 frames through encrypt_function_3 → err=0 and data matches every time.
- Backpressure: stream 8 frames back-to-back with out_ready low for cycles 3–6 → in_ready=0 while full, outputs held stable, all 8 delivered in order, frame_cnt=8.
- Reset mid-stream: Rst_n=0 with 2 frames in flight → next cycle out_valid=0, counters=0, no stale frame delivered after release. Counter saturation: preload CNT_W=4 and send 20 frames → frame_cnt=15.
